multi_key_input: RTL and testbench
==================================

MULTI_KEY_INPUT -- requirements
Module: multi_key_input

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key channels, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel, legal range 2..4.
REQ-003 Parameter DEB_CYCLES, default 8: consecutive clocks of disagreement required to change a debounced level, legal range >=1.
REQ-004 Parameter DAS_TICKS, default 4: input ticks a key is held before the first auto-repeat, legal range >=1.
REQ-005 Parameter ARR_TICKS, default 2: input ticks between subsequent auto-repeats, legal range >=1.
REQ-006 clock  in  1: single clock; every register is updated on its rising edge.
REQ-007 resetn  in  1: reset, synchronous and active-low.
REQ-008 keys_raw  in  N_KEYS: asynchronous raw key inputs, active-high.
REQ-009 tick_input  in  1: one-clock pacing strobe.
REQ-010 repeat_en  in  N_KEYS: per-channel auto-repeat enable.
REQ-011 key_level  out  N_KEYS: registered debounced level per channel.
REQ-012 button  out  N_KEYS: registered one-clock tick-aligned event pulse per channel.

Function
REQ-013 Each channel shall pass keys_raw[i] through a SYNC_STAGES-deep flop chain.
REQ-014 Debounce counter: a counter of width clog2(DEB_CYCLES+1) shall clear on any clock where the synchronized value equals key_level[i], and increment otherwise.
REQ-015 When the debounce counter reaches DEB_CYCLES-1 while disagreement persists, key_level[i] shall toggle on the next edge and the counter shall clear.
REQ-016 Edge detection: a rising-edge flag shall be high for exactly one clock, the clock after key_level[i] rises; falling edges shall produce no event.
REQ-017 Each channel shall hold a pending bit that sets on a rising edge or a repeat fire and clears when an event is emitted.
REQ-018 Emission: button[i] shall be 1 for exactly one clock, the clock after a tick_input=1 sample, when pending, the edge flag or a repeat fire was set in that sampled clock.
REQ-019 Edge coincident with tick: the edge shall be served by that tick, and pending shall not remain set.
REQ-020 Any number of edges or repeat fires between two ticks shall collapse into a single button pulse.
REQ-021 Repeat FSM per channel has states IDLE, DELAY and REPEAT, with a tick counter of width clog2(max(DAS_TICKS,ARR_TICKS)+1).
REQ-022 IDLE -> DELAY on a rising edge when repeat_en[i]=1; the counter clears.
REQ-023 In DELAY, each tick shall increment the counter; on the tick where the counter equals DAS_TICKS-1, a repeat fire shall occur, the FSM moves to REPEAT and the counter clears.
REQ-024 In REPEAT, a repeat fire shall occur on every tick where the counter equals ARR_TICKS-1; the counter clears there and wraps, and otherwise increments.
REQ-025 From any state, key_level[i]=0 or repeat_en[i]=0 shall force IDLE and clear the counter; an already-set pending bit is retained and emitted.
REQ-026 Channels shall be fully independent; simultaneous events on several channels shall pulse their button bits in the same clock.

Reset
REQ-027 While resetn=0 at a clock edge, all synchronizer flops, debounce counters, key_level, edge flags, pending bits, repeat counters and button shall clear to 0, and every FSM shall enter IDLE.
REQ-028 Reset asserted mid-press shall discard pending and repeat state; after release, a still-held key shall be re-debounced and produce a fresh press event.

Configuration
REQ-029 Macro AUTO_REPEAT_EN: when defined, the repeat FSMs and counters shall be built and REQ-021..REQ-025 apply.
REQ-030 When AUTO_REPEAT_EN is undefined, no repeat logic shall be built, repeat_en shall be ignored, and a held key shall yield exactly one button pulse per press.

Verification (N_KEYS=4, SYNC_STAGES=2, DEB_CYCLES=8, DAS_TICKS=4, ARR_TICKS=2, tick every 100 clocks)
REQ-031 Bounce: keys_raw[0] toggles 1,0,1,0 at 1-3 clock intervals, then is stable high -> key_level[0] rises 2+8 clocks after the stable edge, and exactly one button[0] pulse occurs, at the next tick.
REQ-032 Collapse: two clean presses of key 1, both completed between two ticks -> exactly one button[1] pulse.
REQ-033 Auto-repeat (macro defined, repeat_en=4'b0001): key 0 held for 20 ticks -> press pulse, then pulses at ticks +4, +6, +8 ...; release -> pulses stop and the FSM is IDLE.
REQ-034 Macro undefined: the same 20-tick hold -> exactly one button[0] pulse.
REQ-035 Simultaneous: keys 2 and 3 pressed in the same clock -> button=4'b1100 in a single clock.
REQ-036 Reset mid-hold: resetn low for 3 clocks while in REPEAT -> all outputs 0; the held key re-debounces and emits one fresh press pulse.

Source files
------------

// File: rtl/multi_key_input.sv
// Multi-channel key front end: synchronizer, debouncer, rising-edge detector and
// tick-paced event emitter per channel. Define AUTO_REPEAT_EN to build auto-repeat.
module multi_key_input #(
  parameter int N_KEYS      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 8,
  parameter int DAS_TICKS   = 4,
  parameter int ARR_TICKS   = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] keys_raw,
  input  logic              tick_input,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] button
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DAS_LAST = RPT_W'(DAS_TICKS - 1);
  localparam logic [RPT_W-1:0] ARR_LAST = RPT_W'(ARR_TICKS - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;
`else
  logic [31:0] unused_cfg_s;
  assign unused_cfg_s = 32'(DAS_TICKS) ^ 32'(ARR_TICKS) ^ 32'(repeat_en);
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q, level_dly_d;
    logic                   edge_q, edge_d;
    logic                   pend_q, pend_d;
    logic                   button_q, button_d;
    logic                   sync_s;
    logic                   fire_s;

    // Synchronizer, debounce, edge detect and tick-aligned emission next-state.
    always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], keys_raw[i]};
      sync_s      = sync_q[SYNC_STAGES-1];
      level_d     = level_q;
      deb_cnt_d   = {DEB_W{1'b0}};
      if (sync_s == level_q) begin
        deb_cnt_d = {DEB_W{1'b0}};
      end else if (deb_cnt_q == DEB_LAST) begin
        level_d   = ~level_q;
        deb_cnt_d = {DEB_W{1'b0}};
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
      level_dly_d = level_q;
      edge_d      = level_q & ~level_dly_q;
      button_d    = tick_input & (pend_q | edge_q | fire_s);
      // A tick emits whatever is outstanding, so pending never survives one.
      if (tick_input) begin
        pend_d = 1'b0;
      end else begin
        pend_d = pend_q | edge_q | fire_s;
      end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        sync_q      <= {SYNC_STAGES{1'b0}};
        deb_cnt_q   <= {DEB_W{1'b0}};
        level_q     <= 1'b0;
        level_dly_q <= 1'b0;
        edge_q      <= 1'b0;
        pend_q      <= 1'b0;
        button_q    <= 1'b0;
      end else begin
        sync_q      <= sync_d;
        deb_cnt_q   <= deb_cnt_d;
        level_q     <= level_d;
        level_dly_q <= level_dly_d;
        edge_q      <= edge_d;
        pend_q      <= pend_d;
        button_q    <= button_d;
      end
    end

    assign key_level[i] = level_q;
    assign button[i]    = button_q;

`ifdef AUTO_REPEAT_EN
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             fire_c;

    // Repeat FSM next-state. The tick that serves the press itself is not
    // counted, so the first repeat lands DAS_TICKS ticks after the press pulse.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      fire_c    = 1'b0;
      if (!level_q || !repeat_en[i]) begin
        state_d   = RPT_IDLE;
        rpt_cnt_d = {RPT_W{1'b0}};
      end else begin
        case (state_q)
          RPT_IDLE: begin
            if (edge_q) begin
              state_d   = RPT_DELAY;
              rpt_cnt_d = {RPT_W{1'b0}};
            end else begin
              state_d   = RPT_IDLE;
            end
          end
          RPT_DELAY: begin
            if (tick_input && !pend_q) begin
              if (rpt_cnt_q == DAS_LAST) begin
                fire_c    = 1'b1;
                state_d   = RPT_REPEAT;
                rpt_cnt_d = {RPT_W{1'b0}};
              end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
              end
            end else begin
              rpt_cnt_d = rpt_cnt_q;
            end
          end
          RPT_REPEAT: begin
            if (tick_input) begin
              if (rpt_cnt_q == ARR_LAST) begin
                fire_c    = 1'b1;
                rpt_cnt_d = {RPT_W{1'b0}};
              end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
              end
            end else begin
              rpt_cnt_d = rpt_cnt_q;
            end
          end
          default: begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = {RPT_W{1'b0}};
          end
        endcase
      end
    end

    // Repeat FSM state register.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        state_q   <= RPT_IDLE;
        rpt_cnt_q <= {RPT_W{1'b0}};
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign fire_s = fire_c;
`else
    assign fire_s = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_key_input.sv
// Directed bench for multi_key_input: per-clock scoreboard on button plus key_level spot checks.
// Expectations follow the AUTO_REPEAT_EN setting of the build.
module tb_multi_key_input;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic       tick_input;
  logic [3:0] keys_raw;
  logic [3:0] repeat_en;
  logic [3:0] key_level;
  logic [3:0] button;

  int         checks = 0;
  int         errors = 0;
  int         phase  = 0;
  string      step   = "init";
  logic [3:0] exp_q[$];

  always #5 clock = ~clock;

  multi_key_input #(
    .N_KEYS(4), .SYNC_STAGES(2), .DEB_CYCLES(8), .DAS_TICKS(4), .ARR_TICKS(2)
  ) dut (
    .clock(clock), .resetn(resetn), .keys_raw(keys_raw), .tick_input(tick_input),
    .repeat_en(repeat_en), .key_level(key_level), .button(button)
  );

  task automatic check(input string what, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%b expected=%b", step, what, obs, exp);
    end
  endtask

  // One clock: push the expected button for this edge, then pop and compare after it.
  task automatic clk1(input logic tk, input logic [3:0] exp_tick);
    logic [3:0] e;
    tick_input = tk;
    exp_q.push_back((tk && resetn) ? exp_tick : 4'b0000);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("button", button, e);
    phase = tk ? 0 : phase + 1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) clk1(1'b0, 4'b0000);
  endtask

  task automatic run_to(input int p);
    while (phase < p) clk1(1'b0, 4'b0000);
  endtask

  // Finish the current 100-clock tick period; the tick is the 100th clock.
  task automatic to_tick(input logic [3:0] exp);
    while (phase < 99) clk1(1'b0, 4'b0000);
    clk1(1'b1, exp);
  endtask

  function automatic logic [3:0] hold_exp(input int k);
    return (k == 0 || (AR && k >= 4 && (k % 2) == 0)) ? 4'b0001 : 4'b0000;
  endfunction

  initial begin
    int bounce_len[6];
    bounce_len = '{1, 3, 2, 3, 3, 3};
    resetn     = 1'b0;
    tick_input = 1'b0;
    keys_raw   = 4'b0000;
    repeat_en  = 4'b0000;

    step = "reset";
    run(3);
    check("key_level", key_level, 4'b0000);
    resetn = 1'b1;
    phase  = 0;
    step = "idle";
    to_tick(4'b0000);

    // Bounce on key 0, then stable high: level rises on the 10th edge after the stable edge.
    step = "bounce";
    for (int b = 0; b < 6; b++) begin
      keys_raw[0] = ((b % 2) == 0);
      run(bounce_len[b]);
      check("key_level", key_level, 4'b0000);
    end
    keys_raw[0] = 1'b1;
    run(9);
    check("level_pre", key_level, 4'b0000);
    run(1);
    check("level_rise", key_level, 4'b0001);
    to_tick(4'b0001);
    step = "bounce_release";
    keys_raw[0] = 1'b0;
    to_tick(4'b0000);
    check("key_level", key_level, 4'b0000);

    // Two full presses of key 1 between ticks collapse into one pulse.
    step = "collapse";
    keys_raw[1] = 1'b1; run(20);
    keys_raw[1] = 1'b0; run(20);
    keys_raw[1] = 1'b1; run(20);
    keys_raw[1] = 1'b0; run(20);
    to_tick(4'b0010);
    to_tick(4'b0000);

    // Edge flag coincides with the tick: served there, nothing left pending.
    step = "edge_at_tick";
    run_to(88);
    keys_raw[2] = 1'b1;
    to_tick(4'b0100);
    to_tick(4'b0000);
    keys_raw[2] = 1'b0;
    to_tick(4'b0000);

    step = "simultaneous";
    run(30);
    keys_raw[3:2] = 2'b11;
    to_tick(4'b1100);
    keys_raw[3:2] = 2'b00;
    to_tick(4'b0000);
    check("key_level", key_level, 4'b0000);

    // Key 0 held for 20 ticks with repeat enabled on channel 0.
    step = "hold";
    repeat_en   = 4'b0001;
    keys_raw[0] = 1'b1;
    for (int k = 0; k < 20; k++) to_tick(hold_exp(k));
    step = "hold_release";
    keys_raw[0] = 1'b0;
    for (int k = 0; k < 3; k++) to_tick(4'b0000);
    check("key_level", key_level, 4'b0000);

    // Reset while repeating; the held key must re-debounce and press afresh.
    step = "reset_hold";
    keys_raw[0] = 1'b1;
    for (int k = 0; k < 6; k++) to_tick(hold_exp(k));
    run(20);
    resetn = 1'b0;
    run(3);
    check("key_level_rst", key_level, 4'b0000);
    resetn = 1'b1;
    step = "reset_repress";
    to_tick(4'b0001);
    check("key_level", key_level, 4'b0001);
    for (int k = 1; k < 5; k++) to_tick(hold_exp(k));
    keys_raw[0] = 1'b0;
    repeat_en   = 4'b0000;
    to_tick(4'b0000);
    to_tick(4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
